// File: rtl/chaser_pkg.sv
// Shared definitions for the LED chaser: motion-mode codes, FSM state
// encoding, bounce direction codes and the per-mode pass length.
package chaser_pkg;

    localparam logic [1:0] MODE_ROT_L  = 2'b00;
    localparam logic [1:0] MODE_ROT_R  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Number of steps that make up one pass in the given mode.
    function automatic int unsigned pass_len(input logic [1:0] mode, input int unsigned width);
        case (mode)
            MODE_BOUNCE: return 2 * (width - 1);
            MODE_BLINK:  return 2;
            default:     return width;
        endcase
    endfunction

endpackage

// File: rtl/chaser_prescaler.sv
// Step prescaler for the LED chaser.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear of the count (held while the sequencer is idle)
//   enable     : count this cycle (run, not held, not stopping)
//   period     : terminal count; one tick every period+1 enabled cycles
//   tick       : high in the enabled cycle whose edge wraps the count
module chaser_prescaler #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    // Combinational so the sequencer's registered step lands on the wrap edge.
    assign tick = enable && (count == period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/chaser_sequencer.sv
// LED light-chaser controller: owns the pattern register, the run FSM, the
// step/pass counters and the step prescaler.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start, stop  : run control pulses; hold freezes a run while high
//   mode, rate, seed, num_passes : run configuration, sampled at start
//   busy         : high while running
//   step, done   : one-cycle pulses on pattern advance / run end
//   led_pattern  : current pattern
module chaser_sequencer
    import chaser_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] rate,
    input  logic [WIDTH-1:0] seed,
    input  logic [7:0]       num_passes,
    output logic             busy,
    output logic             step,
    output logic             done,
    output logic [WIDTH-1:0] led_pattern
);

    localparam int unsigned CNT_W = $clog2(2 * WIDTH);

    state_t           state;
    logic [1:0]       mode_q;
    logic [DIV_W-1:0] rate_q;
    logic [7:0]       passes_q;
    logic [CNT_W-1:0] step_cnt;
    logic [7:0]       pass_cnt;
    logic             dir;

    logic             tick;
    logic             presc_en;
    logic [WIDTH-1:0] next_pat;
    logic             next_dir;
    logic [WIDTH-1:0] rot_l;
    logic [WIDTH-1:0] rot_r;
    logic [CNT_W-1:0] last_step;
    logic             last_pass;

    // Stop outranks both hold and a coincident expiry, so it gates the prescaler.
    assign presc_en = (state == S_RUN) && !hold && !stop;

    chaser_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == S_IDLE),
        .enable (presc_en),
        .period (rate_q),
        .tick   (tick)
    );

    assign rot_l     = {led_pattern[WIDTH-2:0], led_pattern[WIDTH-1]};
    assign rot_r     = {led_pattern[0], led_pattern[WIDTH-1:1]};
    assign last_step = CNT_W'(pass_len(mode_q, WIDTH) - 1);
    assign last_pass = (passes_q != 8'd0) && (pass_cnt == passes_q - 8'd1);

    always_comb begin
        next_pat = led_pattern;
        next_dir = dir;
        case (mode_q)
            MODE_ROT_L: next_pat = rot_l;
            MODE_ROT_R: next_pat = rot_r;
            MODE_BOUNCE: begin
                // Reverse on reaching an end, then move in the (possibly new) direction.
                if (dir == DIR_LEFT && led_pattern[WIDTH-1]) begin
                    next_dir = DIR_RIGHT;
                end else if (dir == DIR_RIGHT && led_pattern[0]) begin
                    next_dir = DIR_LEFT;
                end
                next_pat = (next_dir == DIR_LEFT) ? rot_l : rot_r;
            end
            MODE_BLINK: next_pat = ~led_pattern;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            mode_q      <= MODE_ROT_L;
            rate_q      <= '0;
            passes_q    <= '0;
            step_cnt    <= '0;
            pass_cnt    <= '0;
            dir         <= DIR_LEFT;
            led_pattern <= '0;
            busy        <= 1'b0;
            step        <= 1'b0;
            done        <= 1'b0;
        end else begin
            step <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q      <= mode;
                        rate_q      <= rate;
                        passes_q    <= num_passes;
                        led_pattern <= (seed == '0) ? WIDTH'(1) : seed;
                        dir         <= DIR_LEFT;
                        step_cnt    <= '0;
                        pass_cnt    <= '0;
                        state       <= S_RUN;
                        busy        <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (tick) begin
                        led_pattern <= next_pat;
                        dir         <= next_dir;
                        step        <= 1'b1;
                        if (step_cnt == last_step) begin
                            step_cnt <= '0;
                            pass_cnt <= pass_cnt + 8'd1;
                            if (last_pass) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
